// File: rtl/io_port.sv
// Responder for the CPU IN/OUT interface: OUT words go into a FWFT output FIFO
// drained by the host; IN words come from a one-entry receive register the host fills.
module io_port #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       out_req,
  input  logic [W-1:0]               out_data,
  input  logic                       in_req,
  output logic [W-1:0]               in_data,
  output logic                       in_ack,
  output logic                       stall,
  output logic                       tx_valid,
  output logic [W-1:0]               tx_data,
  input  logic                       tx_ready,
  input  logic                       rx_valid,
  input  logic [W-1:0]               rx_data,
  output logic                       rx_ready,
  output logic [$clog2(DEPTH):0]     out_count,
  output logic                       proto_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {IDLE, OUT_WAIT, IN_WAIT, ACK} state_t;

  state_t        state;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [W-1:0]  pend;
  logic [W-1:0]  rx_reg;
  logic          rx_full;

  logic          pop;
  logic          space;
  logic          push;
  logic [W-1:0]  push_data;
  logic          rx_accept;

  // FIFO push/pop decisions; a pop frees the slot a same-cycle push may use
  always_comb begin
    pop       = (count != '0) && tx_ready;
    space     = (count < CW'(DEPTH)) || pop;
    rx_accept = rx_valid && !rx_full;
    push      = 1'b0;
    push_data = out_data;
    if (state == IDLE && out_req && space) begin
      push = 1'b1;
    end else if (state == OUT_WAIT && pop) begin
      push      = 1'b1;
      push_data = pend;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pend      <= '0;
      rx_reg    <= '0;
      rx_full   <= 1'b0;
      in_data   <= '0;
      proto_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      // ACK consumes the word; rx_ready is low during ACK so no accept collides
      if (state == ACK) begin
        rx_full <= 1'b0;
      end else if (rx_accept) begin
        rx_full <= 1'b1;
        rx_reg  <= rx_data;
      end

      case (state)
        IDLE: begin
          if (out_req) begin
            if (in_req) proto_err <= 1'b1;
            if (!space) begin
              pend  <= out_data;
              state <= OUT_WAIT;
            end
          end else if (in_req) begin
            if (rx_full) begin
              in_data <= rx_reg;
              state   <= ACK;
            end else begin
              state <= IN_WAIT;
            end
          end
        end
        OUT_WAIT: begin
          if (pop) state <= IDLE;
        end
        IN_WAIT: begin
          if (rx_full) begin
            in_data <= rx_reg;
            state   <= ACK;
          end
        end
        default: state <= IDLE;
      endcase

      if (state != IDLE && (out_req || in_req)) proto_err <= 1'b1;
    end
  end

  assign stall     = (state != IDLE);
  assign in_ack    = (state == ACK);
  assign tx_valid  = (count != '0);
  assign tx_data   = mem[rd_ptr];
  assign rx_ready  = !rx_full;
  assign out_count = count;

endmodule
